// File: rtl/uart8_core.sv
`default_nettype none
// ============================================================================
// Module   : uart8_core
// Purpose  : 8-N-1 UART with independent receiver and transmitter sharing
//            one clock and one reset. The receiver oversamples 16x per bit
//            and samples at bit midpoints. The transmitter shifts at 1x baud.
//            Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop
//            bit (1), no parity.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous, active-high reset
//            rxEn     - receiver enable (0 = ignore line, abort frame)
//            rxIn     - serial input, idle high (asynchronous to clk)
//            rxBusy   - receiver is inside a frame
//            rxDone   - 1-cycle pulse, rxOut holds a new valid byte
//            rxErr    - framing error (stop bit sampled low), sticky
//            rxOut    - last correctly received byte
//            txEn     - transmitter enable (0 = line idle, abort frame)
//            txStart  - send request, sampled while transmitter idle
//            txIn     - byte to send, latched on accepted txStart
//            txBusy   - transmitter is shifting a frame
//            txDone   - 1-cycle pulse at the end of the stop bit
//            txOut    - serial output, idle high
// Revision : 1.0 - initial release
// ============================================================================
module uart8_core #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int c_RX_DIV   = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int c_TX_DIV   = CLOCK_RATE / BAUD_RATE;
  localparam int c_RX_DIV_W = $clog2(c_RX_DIV + 1);
  localparam int c_TX_DIV_W = $clog2(c_TX_DIV + 1);
  localparam logic [c_RX_DIV_W-1:0] c_RX_LAST = c_RX_DIV_W'(c_RX_DIV - 1);
  localparam logic [c_TX_DIV_W-1:0] c_TX_LAST = c_TX_DIV_W'(c_TX_DIV - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxState_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } txState_t;

  // --------------------------------------------------------------------------
  // Receiver input synchroniser and falling-edge detect
  // --------------------------------------------------------------------------
  logic [1:0] r_rxSync;
  logic       r_rxPrev;
  logic       w_rxLine;
  logic       w_rxFall;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Preset to the idle level so reset release never looks like a start edge
      r_rxSync <= 2'b11;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxSync <= {r_rxSync[0], rxIn};
      r_rxPrev <= r_rxSync[1];
    end
  end

  assign w_rxLine = r_rxSync[1];
  assign w_rxFall = r_rxPrev & ~w_rxLine;

  // --------------------------------------------------------------------------
  // Receiver FSM with 16x oversampling tick
  // --------------------------------------------------------------------------
  rxState_t              r_rxState;
  logic [c_RX_DIV_W-1:0] r_rxDivCnt;
  logic [3:0]            r_rxTickCnt;
  logic [2:0]            r_rxBitCnt;
  logic [7:0]            r_rxShift;
  logic                  w_rxTick;

  assign w_rxTick = (r_rxDivCnt == c_RX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxState   <= RX_IDLE;
      r_rxDivCnt  <= '0;
      r_rxTickCnt <= '0;
      r_rxBitCnt  <= '0;
      r_rxShift   <= '0;
      rxBusy      <= 1'b0;
      rxDone      <= 1'b0;
      rxErr       <= 1'b0;
      rxOut       <= 8'h00;
    end else begin
      rxDone <= 1'b0;
      if (!rxEn) begin
        // Disabled: drop any frame in progress, hold the tick divider
        r_rxState  <= RX_IDLE;
        r_rxDivCnt <= '0;
        rxBusy     <= 1'b0;
      end else begin
        r_rxDivCnt <= w_rxTick ? '0 : r_rxDivCnt + 1'b1;
        case (r_rxState)
          RX_IDLE: begin
            if (w_rxFall) begin
              // Re-phase the tick divider to the start edge
              r_rxState   <= RX_START;
              r_rxDivCnt  <= '0;
              r_rxTickCnt <= '0;
              rxBusy      <= 1'b1;
              rxErr       <= 1'b0;
            end
          end
          RX_START: begin
            if (w_rxTick) begin
              r_rxTickCnt <= r_rxTickCnt + 1'b1;
              if (r_rxTickCnt == 4'd7) begin
                // Middle of the start bit; a high line means it was a glitch
                r_rxTickCnt <= '0;
                if (!w_rxLine) begin
                  r_rxState  <= RX_DATA;
                  r_rxBitCnt <= '0;
                end else begin
                  r_rxState <= RX_IDLE;
                  rxBusy    <= 1'b0;
                end
              end
            end
          end
          RX_DATA: begin
            if (w_rxTick) begin
              // Tick count wraps 15 -> 0, so every 16th tick is a midpoint
              r_rxTickCnt <= r_rxTickCnt + 1'b1;
              if (r_rxTickCnt == 4'd15) begin
                r_rxShift  <= {w_rxLine, r_rxShift[7:1]};
                r_rxBitCnt <= r_rxBitCnt + 1'b1;
                if (r_rxBitCnt == 3'd7) begin
                  r_rxState <= RX_STOP;
                end
              end
            end
          end
          RX_STOP: begin
            if (w_rxTick) begin
              r_rxTickCnt <= r_rxTickCnt + 1'b1;
              if (r_rxTickCnt == 4'd15) begin
                // Return to idle at the stop midpoint so a short stop bit
                // followed by an early start edge is still caught
                r_rxState <= RX_IDLE;
                rxBusy    <= 1'b0;
                if (w_rxLine) begin
                  rxOut  <= r_rxShift;
                  rxDone <= 1'b1;
                end else begin
                  rxErr <= 1'b1;
                end
              end
            end
          end
          default: begin
            r_rxState <= RX_IDLE;
            rxBusy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transmitter FSM, one bit every c_TX_DIV clocks
  // --------------------------------------------------------------------------
  txState_t              r_txState;
  logic [c_TX_DIV_W-1:0] r_txDivCnt;
  logic [2:0]            r_txBitCnt;
  logic [7:0]            r_txShift;
  logic                  w_txBitEnd;

  assign w_txBitEnd = (r_txDivCnt == c_TX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_txState  <= TX_IDLE;
      r_txDivCnt <= '0;
      r_txBitCnt <= '0;
      r_txShift  <= '0;
      txBusy     <= 1'b0;
      txDone     <= 1'b0;
      txOut      <= 1'b1;
    end else begin
      txDone <= 1'b0;
      if (!txEn) begin
        r_txState  <= TX_IDLE;
        r_txDivCnt <= '0;
        txBusy     <= 1'b0;
        txOut      <= 1'b1;
      end else begin
        r_txDivCnt <= w_txBitEnd ? '0 : r_txDivCnt + 1'b1;
        case (r_txState)
          TX_IDLE: begin
            r_txDivCnt <= '0;
            if (txStart) begin
              r_txShift <= txIn;
              r_txState <= TX_START;
              txBusy    <= 1'b1;
              txOut     <= 1'b0;
            end
          end
          TX_START: begin
            if (w_txBitEnd) begin
              r_txState  <= TX_DATA;
              r_txBitCnt <= '0;
              txOut      <= r_txShift[0];
            end
          end
          TX_DATA: begin
            if (w_txBitEnd) begin
              if (r_txBitCnt == 3'd7) begin
                r_txState <= TX_STOP;
                txOut     <= 1'b1;
              end else begin
                // The bit going out next is bit 1 of the current shift value
                r_txShift  <= {1'b0, r_txShift[7:1]};
                r_txBitCnt <= r_txBitCnt + 1'b1;
                txOut      <= r_txShift[1];
              end
            end
          end
          TX_STOP: begin
            if (w_txBitEnd) begin
              r_txState <= TX_IDLE;
              txBusy    <= 1'b0;
              txDone    <= 1'b1;
            end
          end
          default: begin
            r_txState <= TX_IDLE;
            txBusy    <= 1'b0;
            txOut     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart8_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart8_core
// Purpose  : Directed self-checking bench for uart8_core at 12 MHz / 9600 bd.
//            Receive path driven at 1290 clocks per bit (107.5 us), transmit
//            path checked bit by bit and looped back into the receiver.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart8_core;

  localparam int RX_BIT = 1290;  // 107.5 us at 12 MHz
  localparam int TX_BIT = 1250;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxEn;
  logic       rxBusy;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxOut;
  logic       txEn;
  logic       txStart;
  logic [7:0] txIn;
  logic       txBusy;
  logic       txDone;
  logic       txOut;
  logic       rxDrv;
  logic       loopBack;
  logic       rxLine;

  int passCnt  = 0;
  int totalCnt = 0;
  int rxDoneTotal = 0;

  always #5 clk = ~clk;

  assign rxLine = loopBack ? txOut : rxDrv;

  always @(posedge clk) begin
    if (rxDone === 1'b1) rxDoneTotal <= rxDoneTotal + 1;
  end

  uart8_core #(
    .CLOCK_RATE(12000000),
    .BAUD_RATE (9600)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rxEn   (rxEn),
    .rxIn   (rxLine),
    .rxBusy (rxBusy),
    .rxDone (rxDone),
    .rxErr  (rxErr),
    .rxOut  (rxOut),
    .txEn   (txEn),
    .txStart(txStart),
    .txIn   (txIn),
    .txBusy (txBusy),
    .txDone (txDone),
    .txOut  (txOut)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rxBit(input logic v, input int n);
    rxDrv = v;
    waitClk(n);
  endtask

  task automatic rxData(input logic [7:0] d);
    for (int i = 0; i < 8; i++) rxBit(d[i], RX_BIT);
  endtask

  initial begin
    int base;
    logic [9:0] txExp;

    reset = 1'b1; rxEn = 1'b1; txEn = 1'b1; txStart = 1'b0;
    txIn = 8'h00; rxDrv = 1'b1; loopBack = 1'b0;
    waitClk(3);
    check("rst_rxBusy", 8'(rxBusy), 8'd0);
    check("rst_rxDone", 8'(rxDone), 8'd0);
    check("rst_rxErr",  8'(rxErr),  8'd0);
    check("rst_rxOut",  rxOut,      8'h00);
    check("rst_txBusy", 8'(txBusy), 8'd0);
    check("rst_txDone", 8'(txDone), 8'd0);
    check("rst_txOut",  8'(txOut),  8'd1);
    reset = 1'b0;
    waitClk(20);

    // Frame 0x56 at 3% slow baud
    base = rxDoneTotal;
    rxBit(1'b0, RX_BIT);
    check("rx56_busyMid", 8'(rxBusy), 8'd1);
    rxData(8'h56);
    rxBit(1'b1, RX_BIT);
    check("rx56_out",   rxOut, 8'h56);
    check("rx56_done",  8'(rxDoneTotal - base), 8'd1);
    check("rx56_err",   8'(rxErr),  8'd0);
    check("rx56_busy",  8'(rxBusy), 8'd0);

    // 16 us glitch: start detected, rejected at start-bit midpoint
    base = rxDoneTotal;
    rxBit(1'b0, 192);
    rxDrv = 1'b1;
    check("glitch_busyEarly", 8'(rxBusy), 8'd1);
    waitClk(700);
    check("glitch_busy", 8'(rxBusy), 8'd0);
    check("glitch_done", 8'(rxDoneTotal - base), 8'd0);
    check("glitch_err",  8'(rxErr), 8'd0);

    // Stop bit low -> framing error, rxOut kept
    base = rxDoneTotal;
    rxBit(1'b0, RX_BIT);
    rxData(8'h56);
    rxBit(1'b0, RX_BIT);
    rxBit(1'b1, 100);
    check("ferr_err",  8'(rxErr), 8'd1);
    check("ferr_done", 8'(rxDoneTotal - base), 8'd0);
    check("ferr_out",  rxOut, 8'h56);
    check("ferr_busy", 8'(rxBusy), 8'd0);

    // Short 71 us stop bit followed immediately by a new start
    base = rxDoneTotal;
    rxBit(1'b0, RX_BIT);
    rxData(8'h11);
    rxBit(1'b1, 852);
    rxBit(1'b0, RX_BIT);
    rxBit(1'b0, RX_BIT);  // bits 0..2 of 0x56: 0,1,1
    rxBit(1'b1, RX_BIT);
    rxBit(1'b1, RX_BIT);
    check("short_out",  rxOut, 8'h11);
    check("short_done", 8'(rxDoneTotal - base), 8'd1);
    check("short_busy", 8'(rxBusy), 8'd1);
    check("short_err",  8'(rxErr), 8'd0);
    rxEn = 1'b0;
    waitClk(2);
    check("rxEnOff_busy", 8'(rxBusy), 8'd0);
    check("rxEnOff_out",  rxOut, 8'h11);
    rxDrv = 1'b1;
    waitClk(5);
    rxEn = 1'b1;
    waitClk(20);

    // Reset in the middle of both an RX and a TX frame
    txIn = 8'h3C; txStart = 1'b1;
    waitClk(1);
    txStart = 1'b0;
    rxBit(1'b0, RX_BIT);
    rxBit(1'b0, RX_BIT);
    rxBit(1'b1, RX_BIT);
    check("pre_rxBusy", 8'(rxBusy), 8'd1);
    check("pre_txBusy", 8'(txBusy), 8'd1);
    reset = 1'b1;
    waitClk(1);
    check("mid_rxBusy", 8'(rxBusy), 8'd0);
    check("mid_rxDone", 8'(rxDone), 8'd0);
    check("mid_rxErr",  8'(rxErr),  8'd0);
    check("mid_rxOut",  rxOut,      8'h00);
    check("mid_txBusy", 8'(txBusy), 8'd0);
    check("mid_txDone", 8'(txDone), 8'd0);
    check("mid_txOut",  8'(txOut),  8'd1);
    reset = 1'b0;
    rxDrv = 1'b1;
    waitClk(50);

    // Transmit 0xA5 looped back into the receiver
    loopBack = 1'b1;
    waitClk(10);
    base = rxDoneTotal;
    txExp = 10'b1_1010_0101_0;  // stop, data MSB..LSB, start
    txIn = 8'hA5; txStart = 1'b1;
    waitClk(1);
    txStart = 1'b0;
    waitClk(TX_BIT / 2);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), 8'(txOut), 8'(txExp[k]));
      if (k < 9) waitClk(TX_BIT);
    end
    waitClk(TX_BIT / 2 - 1);
    check("tx_doneEarly", 8'(txDone), 8'd0);
    check("tx_busyLate",  8'(txBusy), 8'd1);
    waitClk(1);
    check("tx_done",     8'(txDone), 8'd1);
    check("tx_busyIdle", 8'(txBusy), 8'd0);
    check("loop_out",    rxOut, 8'hA5);
    check("loop_done",   8'(rxDoneTotal - base), 8'd1);
    check("loop_err",    8'(rxErr), 8'd0);
    waitClk(1);
    check("tx_donePulse", 8'(txDone), 8'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
`default_nettype wire
